// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor responder: FSM states,
// channel ids, the misaligned-access result word and the latency counter width.
package coproc_pkg;

    localparam int LAT_W = 4;
    localparam logic [31:0] MISALIGN_RESULT = 32'hDEAD_0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MEMRD = 3'd1,
        ST_CAPT  = 3'd2,
        ST_DELAY = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    typedef enum logic {
        CH_LOGIC = 1'b0,
        CH_PY    = 1'b1
    } ch_id_t;

endpackage

// File: rtl/coproc_responder_if.sv
// Request/ack channels plus backing-memory port of the coprocessor responder.
// master = CPU and memory side, slave = responder.
interface coproc_responder_if;

    logic        logic_req;
    logic [31:0] logic_addr;
    logic        logic_ack;
    logic [31:0] logic_data;

    logic        py_req;
    logic [31:0] py_code_addr;
    logic        py_ack;
    logic [31:0] py_result;

    logic        bk_en;
    logic [31:0] bk_addr;
    logic [31:0] bk_rdata;

    modport master (
        output logic_req, logic_addr, py_req, py_code_addr, bk_rdata,
        input  logic_ack, logic_data, py_ack, py_result, bk_en, bk_addr
    );

    modport slave (
        input  logic_req, logic_addr, py_req, py_code_addr, bk_rdata,
        output logic_ack, logic_data, py_ack, py_result, bk_en, bk_addr
    );

endinterface

// File: rtl/coproc_arbiter.sv
// Per-channel armed flags, eligibility and grant selection.
// COPROC_RESP_RR_EN selects round-robin; otherwise the logic channel has fixed priority.
module coproc_arbiter
    import coproc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   logic_req,
    input  logic   py_req,
    input  logic   accept,
    input  logic   ack_fire,
    output logic   grant_valid,
    output ch_id_t grant_id
);

    logic [1:0] req_vec;
    logic [1:0] armed_reg;
    logic [1:0] armed_next;
    logic [1:0] elig;

    assign req_vec = {py_req, logic_req};

    // A held request stays disarmed until its req is seen low, so it is never served twice.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arm
            localparam ch_id_t CH = (gi == 0) ? CH_LOGIC : CH_PY;

            always_comb begin
                armed_next[gi] = armed_reg[gi];
                if (!req_vec[gi]) begin
                    armed_next[gi] = 1'b1;
                end else if (accept && (grant_id == CH)) begin
                    armed_next[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    armed_reg[gi] <= 1'b1;
                end else begin
                    armed_reg[gi] <= armed_next[gi];
                end
            end

            assign elig[gi] = req_vec[gi] & armed_reg[gi];
        end
    endgenerate

    assign grant_valid = |elig;

`ifdef COPROC_RESP_RR_EN
    ch_id_t rr_ptr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= CH_LOGIC;
        end else if (ack_fire) begin
            rr_ptr_reg <= (rr_ptr_reg == CH_LOGIC) ? CH_PY : CH_LOGIC;
        end
    end

    always_comb begin
        grant_id = CH_LOGIC;
        if (elig == 2'b11) begin
            grant_id = rr_ptr_reg;
        end else if (elig[1]) begin
            grant_id = CH_PY;
        end
    end
`else
    logic unused_ack_fire;
    assign unused_ack_fire = ack_fire;

    always_comb begin
        grant_id = CH_LOGIC;
        if (!elig[0] && elig[1]) begin
            grant_id = CH_PY;
        end
    end
`endif

endmodule

// File: rtl/coproc_responder.sv
// Coprocessor responder: serves logic and Python requests from one backing memory.
// Optional macro COPROC_RESP_RR_EN enables round-robin arbitration between channels.
module coproc_responder
    import coproc_pkg::*;
#(
    parameter int LOGIC_LAT = 2,
    parameter int PY_LAT    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    coproc_responder_if.slave  bus,
    output logic               busy,
    output logic [15:0]        served_count,
    output logic               err_misalign
);

    localparam logic [LAT_W-1:0] LOGIC_LAT_W = LAT_W'(LOGIC_LAT);
    localparam logic [LAT_W-1:0] PY_LAT_W    = LAT_W'(PY_LAT);

    state_t            state_reg;
    state_t            state_next;
    ch_id_t            ch_reg;
    logic              misalign_reg;
    logic [LAT_W-1:0]  cnt_reg;
    logic [31:0]       result_reg;
    logic [31:0]       logic_data_reg;
    logic [31:0]       py_result_reg;
    logic              bk_en_reg;
    logic [31:0]       bk_addr_reg;
    logic [15:0]       served_count_reg;

    logic              grant_valid;
    ch_id_t            grant_id;
    logic              accept;
    logic              ack_fire;
    logic [31:0]       sel_addr;
    logic [31:0]       capt_result;

    // The ack cycle doubles as an idle slot so the other channel can start back-to-back.
    assign accept   = ((state_reg == ST_IDLE) || (state_reg == ST_ACK)) && grant_valid;
    assign ack_fire = (state_reg == ST_ACK);
    assign sel_addr = (grant_id == CH_LOGIC) ? bus.logic_addr : bus.py_code_addr;

    coproc_arbiter u_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .logic_req   (bus.logic_req),
        .py_req      (bus.py_req),
        .accept      (accept),
        .ack_fire    (ack_fire),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_valid) state_next = ST_MEMRD;
            ST_MEMRD: state_next = ST_CAPT;
            ST_CAPT:  state_next = ST_DELAY;
            ST_DELAY: if (cnt_reg == '0) state_next = ST_ACK;
            ST_ACK:   state_next = grant_valid ? ST_MEMRD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.logic_ack = 1'b0;
        bus.py_ack    = 1'b0;
        err_misalign  = 1'b0;
        busy          = (state_reg != ST_IDLE);
        if (state_reg == ST_ACK) begin
            bus.logic_ack = (ch_reg == CH_LOGIC);
            bus.py_ack    = (ch_reg == CH_PY);
            err_misalign  = misalign_reg;
        end
    end

    always_comb begin
        capt_result = bus.bk_rdata;
        if (misalign_reg) begin
            capt_result = MISALIGN_RESULT;
        end else if (ch_reg == CH_PY) begin
            capt_result = bus.bk_rdata + 32'd1;
        end
    end

    // Result registers update on entry to ACK so data is valid alongside the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_reg           <= CH_LOGIC;
            misalign_reg     <= 1'b0;
            cnt_reg          <= '0;
            result_reg       <= '0;
            logic_data_reg   <= '0;
            py_result_reg    <= '0;
            bk_en_reg        <= 1'b0;
            bk_addr_reg      <= '0;
            served_count_reg <= '0;
        end else begin
            if (accept) begin
                ch_reg       <= grant_id;
                misalign_reg <= (sel_addr[1:0] != 2'b00);
                bk_en_reg    <= (sel_addr[1:0] == 2'b00);
                if (sel_addr[1:0] == 2'b00) begin
                    bk_addr_reg <= sel_addr;
                end
            end
            case (state_reg)
                ST_MEMRD: bk_en_reg <= 1'b0;
                ST_CAPT: begin
                    result_reg <= capt_result;
                    cnt_reg    <= (ch_reg == CH_LOGIC) ? LOGIC_LAT_W : PY_LAT_W;
                end
                ST_DELAY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - LAT_W'(1);
                    end else begin
                        if (ch_reg == CH_LOGIC) begin
                            logic_data_reg <= result_reg;
                        end else begin
                            py_result_reg <= result_reg;
                        end
                        served_count_reg <= served_count_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.logic_data = logic_data_reg;
    assign bus.py_result  = py_result_reg;
    assign bus.bk_en      = bk_en_reg;
    assign bus.bk_addr    = bk_addr_reg;
    assign served_count   = served_count_reg;

endmodule

// File: tb/tb_coproc_responder.sv
// Scoreboard bench for coproc_responder (default build: fixed logic priority).
// Stimulus pushes expected acks; a negedge monitor pops and compares them.
module tb_coproc_responder;
    import coproc_pkg::*;

    localparam int LOGIC_LAT = 2;
    localparam int PY_LAT    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] served_count;
    logic        err_misalign;

    coproc_responder_if bus();

    coproc_responder #(.LOGIC_LAT(LOGIC_LAT), .PY_LAT(PY_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .busy         (busy),
        .served_count (served_count),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (bus.bk_en) bus.bk_rdata <= mem[bus.bk_addr[7:2]];
    end

    typedef struct {
        bit          ch;
        logic [31:0] data;
        bit          mis;
        int          at;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          bk_cnt = 0;
    logic [31:0] bk_last = '0;
    logic [15:0] exp_count = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(bit ch, logic [31:0] d, bit mis, int at);
        exp_count++;
        sb.push_back('{ch, d, mis, at, exp_count});
    endtask

    // Called at a negedge with the DUT idle: E0 is the next posedge.
    task automatic issue(bit ch, logic [31:0] addr, logic [31:0] d, bit mis, int lat);
        if (ch == 1'b0) begin
            bus.logic_req  = 1'b1;
            bus.logic_addr = addr;
        end else begin
            bus.py_req       = 1'b1;
            bus.py_code_addr = addr;
        end
        $display("issue ch=%0d addr=%h expect data=%h mis=%0d at cycle %0d", ch, addr, d, mis, cyc + 4 + lat);
        push(ch, d, mis, cyc + 4 + lat);
    endtask

    task automatic wait_acks(bit drop);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (drop) begin
                if (bus.logic_ack) bus.logic_req = 1'b0;
                if (bus.py_ack)    bus.py_req    = 1'b0;
            end
        end
        check("ack_timeout_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_logic_ack"},    32'(bus.logic_ack), 32'd0);
        check({tag, "_py_ack"},       32'(bus.py_ack),    32'd0);
        check({tag, "_busy"},         32'(busy),          32'd0);
        check({tag, "_bk_en"},        32'(bus.bk_en),     32'd0);
        check({tag, "_err"},          32'(err_misalign),  32'd0);
        check({tag, "_served_count"}, 32'(served_count),  32'd0);
        check({tag, "_logic_data"},   bus.logic_data,     32'd0);
        check({tag, "_py_result"},    bus.py_result,      32'd0);
        check({tag, "_bk_addr"},      bus.bk_addr,        32'd0);
    endtask

    // Monitor: pops one expectation per ack and checks data, timing and side outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.bk_en) begin
                bk_cnt++;
                bk_last = bus.bk_addr;
            end
            if (err_misalign && !(bus.logic_ack || bus.py_ack)) begin
                n_vec++;
                n_err++;
                $display("FAIL err_without_ack: err_misalign=1, expected 0 (cycle %0d)", cyc);
            end
            if (bus.logic_ack || bus.py_ack) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: logic_ack=%b py_ack=%b, expected no ack (cycle %0d)",
                             bus.logic_ack, bus.py_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    $display("ack ch=%0d data=%h err=%0d count=%0d cycle=%0d",
                             bus.py_ack, e.ch ? bus.py_result : bus.logic_data, err_misalign, served_count, cyc);
                    check("single_ack",   32'(bus.logic_ack & bus.py_ack), 32'd0);
                    check("ack_channel",  32'(bus.py_ack), 32'(e.ch));
                    check("ack_data",     e.ch ? bus.py_result : bus.logic_data, e.data);
                    check("err_misalign", 32'(err_misalign), 32'(e.mis));
                    check("ack_cycle",    32'(cyc), 32'(e.at));
                    check("served_count", 32'(served_count), 32'(e.cnt));
                    check("busy_at_ack",  32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int b0;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h0101_0101;
        mem[4]  = 32'hABCD_1234;   // 0x10
        mem[5]  = 32'h0BAD_F00D;   // 0x14
        mem[6]  = 32'h1357_2468;   // 0x18
        mem[8]  = 32'h1234_5677;   // 0x20
        mem[9]  = 32'hFFFF_FFFF;   // 0x24
        mem[10] = 32'h7FFF_FFFF;   // 0x28
        bus.logic_req    = 1'b0;
        bus.logic_addr   = '0;
        bus.py_req       = 1'b0;
        bus.py_code_addr = '0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Plain logic read
        b0 = bk_cnt;
        issue(1'b0, 32'h10, 32'hABCD_1234, 1'b0, LOGIC_LAT);
        wait_acks(1'b1);
        check("bk_en_cycles", 32'(bk_cnt - b0), 32'd1);
        check("bk_addr",      bk_last,          32'h10);

        // Python increment, then increment with wrap
        issue(1'b1, 32'h20, 32'h1234_5678, 1'b0, PY_LAT);
        wait_acks(1'b1);
        issue(1'b1, 32'h24, 32'h0000_0000, 1'b0, PY_LAT);
        wait_acks(1'b1);

        // Two rounds of simultaneous requests: logic wins, python follows back-to-back
        n = cyc;
        bus.logic_req = 1'b1; bus.logic_addr   = 32'h10;
        bus.py_req    = 1'b1; bus.py_code_addr = 32'h20;
        push(1'b0, 32'hABCD_1234, 1'b0, n + 4 + LOGIC_LAT);
        push(1'b1, 32'h1234_5678, 1'b0, n + 4 + LOGIC_LAT + 1 + 3 + PY_LAT);
        wait_acks(1'b1);
        n = cyc;
        bus.logic_req = 1'b1; bus.logic_addr   = 32'h14;
        bus.py_req    = 1'b1; bus.py_code_addr = 32'h28;
        push(1'b0, 32'h0BAD_F00D, 1'b0, n + 4 + LOGIC_LAT);
        push(1'b1, 32'h8000_0000, 1'b0, n + 4 + LOGIC_LAT + 1 + 3 + PY_LAT);
        wait_acks(1'b1);

        // Held request: one ack only until req is dropped and re-raised
        issue(1'b0, 32'h18, 32'h1357_2468, 1'b0, LOGIC_LAT);
        wait_acks(1'b0);
        repeat (20) @(negedge clk);
        check("held_served_count", 32'(served_count), 32'(exp_count));
        bus.logic_req = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h18, 32'h1357_2468, 1'b0, LOGIC_LAT);
        wait_acks(1'b1);

        // Misaligned addresses on both channels: no memory access, fixed result
        b0 = bk_cnt;
        issue(1'b0, 32'h13, 32'hDEAD_0001, 1'b1, LOGIC_LAT);
        wait_acks(1'b1);
        issue(1'b1, 32'h22, 32'hDEAD_0001, 1'b1, PY_LAT);
        wait_acks(1'b1);
        check("bk_en_misaligned", 32'(bk_cnt - b0), 32'd0);

        // Reset while the python request sits in DELAY: dropped, no ack
        bus.py_req       = 1'b1;
        bus.py_code_addr = 32'h20;
        repeat (5) @(negedge clk);
        check("busy_in_delay", 32'(busy), 32'd1);
        rst_n      = 1'b0;
        bus.py_req = 1'b0;
        @(negedge clk);
        check_idle("midop_reset");
        rst_n     = 1'b1;
        exp_count = '0;
        repeat (12) @(negedge clk);
        check("served_after_reset", 32'(served_count), 32'd0);
        issue(1'b0, 32'h10, 32'hABCD_1234, 1'b0, LOGIC_LAT);
        wait_acks(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
